// File: rtl/timer_sched.sv
// timer_sched: programmable down-count timer controller.
//
// Counts a WIDTH-bit value down to zero. One count step occurs every (pre_div+1)
// clk cycles. Supports one-shot and auto-reload (periodic) modes, pause, and
// abort. Every output is a flop.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   start     latch configuration and (re)start the timer
//   stop      abort and return to idle (highest priority)
//   pause     level; freezes the timer while high in run/pause
//   periodic  mode latched at start: 1 auto-reload, 0 one-shot
//   load_val  initial and reload count, latched at start
//   pre_div   prescaler divide value, latched at start
//   count     current count value
//   state     0 idle, 1 run, 2 pause, 3 done
//   busy      state is run or pause
//   done      state is done
//   tick      single-cycle pulse on terminal count
module timer_sched #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned PRE_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 pause,
   input  logic                 periodic,
   input  logic [WIDTH-1:0]     load_val,
   input  logic [PRE_WIDTH-1:0] pre_div,
   output logic [WIDTH-1:0]     count,
   output logic [1:0]           state,
   output logic                 busy,
   output logic                 done,
   output logic                 tick
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StDone  = 2'd3
   } state_e;

   state_e               st;
   logic [PRE_WIDTH-1:0] presc;
   logic [PRE_WIDTH-1:0] pdiv;
   logic [WIDTH-1:0]     reload;
   logic                 mode;

   assign state = st;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st     <= StIdle;
         count  <= '0;
         presc  <= '0;
         pdiv   <= '0;
         reload <= '0;
         mode   <= 1'b0;
         tick   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else if (stop) begin
         st    <= StIdle;
         count <= '0;
         presc <= '0;
         tick  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (start) begin
         count  <= load_val;
         reload <= load_val;
         pdiv   <= pre_div;
         mode   <= periodic;
         presc  <= '0;
         if (load_val == '0) begin
            // Zero load is an immediate terminal count.
            tick <= 1'b1;
            if (periodic) begin
               st   <= StRun;
               busy <= 1'b1;
               done <= 1'b0;
            end else begin
               st   <= StDone;
               busy <= 1'b0;
               done <= 1'b1;
            end
         end else begin
            tick <= 1'b0;
            st   <= StRun;
            busy <= 1'b1;
            done <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
         case (st)
            StRun: begin
               if (pause) begin
                  // Entering pause freezes count and prescaler; no step this edge.
                  st <= StPause;
               end else if (presc == pdiv) begin
                  presc <= '0;
                  if (count > WIDTH'(1)) begin
                     count <= count - 1'b1;
                  end else if (count == WIDTH'(1)) begin
                     count <= '0;
                     tick  <= 1'b1;
                     if (!mode) begin
                        st   <= StDone;
                        busy <= 1'b0;
                        done <= 1'b1;
                     end
                  end else begin
                     // Only reachable in periodic mode: reload after terminal count.
                     count <= reload;
                     tick  <= (reload == '0);
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            StPause: begin
               if (!pause) st <= StRun;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: a vector table, hand-written corner
// sequences, and randomized stimulus against a behavioural model.
module tb_timer_sched;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned PRE_WIDTH = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 start = 1'b0, stop = 1'b0, pause = 1'b0, periodic = 1'b0;
   logic [WIDTH-1:0]     load_val = '0;
   logic [PRE_WIDTH-1:0] pre_div = '0;
   logic [WIDTH-1:0]     count;
   logic [1:0]           state;
   logic                 busy, done, tick;

   int n_chk  = 0;
   int n_fail = 0;

   timer_sched #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .periodic(periodic), .load_val(load_val), .pre_div(pre_div),
      .count(count), .state(state), .busy(busy), .done(done), .tick(tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit start, stop, pause, periodic;
      int load, pdiv;
      int e_count, e_state, e_tick;
   } vec_t;

   vec_t vecs[30];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input int ec, input int es, input int et);
      chk({tag, " count"}, int'(count), ec);
      chk({tag, " state"}, int'(state), es);
      chk({tag, " tick"}, int'(tick), et);
      chk({tag, " busy"}, int'(busy), int'(es == 1 || es == 2));
      chk({tag, " done"}, int'(done), int'(es == 3));
   endtask

   task automatic drive(input bit s, input bit p, input bit ps, input bit per,
                        input int ld, input int pd);
      start = s; stop = p; pause = ps; periodic = per;
      load_val = WIDTH'(ld); pre_div = PRE_WIDTH'(pd);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: state numbers as in the port description.
   int m_state, m_count, m_presc, m_reload, m_pdiv, m_tick;
   bit m_mode;

   task automatic model_edge(input bit s, input bit p, input bit ps, input bit per,
                             input int ld, input int pd);
      m_tick = 0;
      if (p) begin
         m_state = 0; m_count = 0; m_presc = 0;
      end else if (s) begin
         m_count = ld; m_reload = ld; m_pdiv = pd; m_mode = per; m_presc = 0;
         m_state = 1;
         if (ld == 0) begin
            m_tick = 1;
            if (!per) m_state = 3;
         end
      end else if (m_state == 1) begin
         if (ps) m_state = 2;
         else if (m_presc < m_pdiv) m_presc++;
         else begin
            m_presc = 0;
            if (m_count == 0) begin
               m_count = m_reload;
               m_tick  = (m_reload == 0);
            end else begin
               m_count--;
               if (m_count == 0) begin
                  m_tick = 1;
                  if (!m_mode) m_state = 3;
               end
            end
         end
      end else if (m_state == 2 && !ps) begin
         m_state = 1;
      end
   endtask

   function automatic vec_t mk(bit s, bit p, bit ps, bit per, int ld, int pd,
                               int ec, int es, int et);
      vec_t v;
      v.start = s; v.stop = p; v.pause = ps; v.periodic = per;
      v.load = ld; v.pdiv = pd; v.e_count = ec; v.e_state = es; v.e_tick = et;
      return v;
   endfunction

   initial begin
      int t;
      bit got;
      // One-shot load 3, pre_div 0.
      vecs[0]  = mk(1, 0, 0, 0, 3, 0, 3, 1, 0);
      vecs[1]  = mk(0, 0, 0, 1, 9, 5, 2, 1, 0);
      vecs[2]  = mk(0, 0, 0, 0, 9, 5, 1, 1, 0);
      vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 1);
      vecs[4]  = mk(0, 0, 1, 0, 0, 0, 0, 3, 0);
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 0);
      // Periodic load 2, pre_div 1: restart from done.
      vecs[6]  = mk(1, 0, 0, 1, 2, 1, 2, 1, 0);
      vecs[7]  = mk(0, 0, 0, 0, 7, 0, 2, 1, 0);
      vecs[8]  = mk(0, 0, 0, 0, 7, 0, 1, 1, 0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
      vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 2, 1, 0);
      vecs[13] = mk(0, 0, 0, 0, 0, 0, 2, 1, 0);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
      vecs[15] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
      vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
      // Pause/resume, then start+stop together, pause in idle.
      vecs[17] = mk(0, 0, 1, 0, 0, 0, 0, 2, 0);
      vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[20] = mk(0, 0, 0, 0, 0, 0, 2, 1, 0);
      vecs[21] = mk(1, 1, 0, 0, 5, 0, 0, 0, 0);
      vecs[22] = mk(0, 0, 1, 0, 5, 0, 0, 0, 0);
      // Zero load: one-shot then periodic with pre_div 2.
      vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 3, 1);
      vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 3, 0);
      vecs[25] = mk(1, 0, 0, 1, 0, 2, 0, 1, 1);
      vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
      vecs[29] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);

      // Reset state.
      #12;
      chk_all("reset", 0, 0, 0);
      rst = 1'b1;
      cyc();
      chk_all("post-reset idle", 0, 0, 0);

      for (int i = 0; i < 30; i++) begin
         drive(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].periodic,
               vecs[i].load, vecs[i].pdiv);
         cyc();
         chk_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_state, vecs[i].e_tick);
      end

      // Async reset mid-run with count 5.
      drive(1, 0, 0, 0, 9, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
      repeat (4) cyc();
      chk("pre-reset count", int'(count), 5);
      #3 rst = 1'b0;
      #1 chk_all("async reset", 0, 0, 0);
      drive(1, 0, 0, 1, 4, 0);
      cyc();
      chk_all("inputs ignored in reset", 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      #2 rst = 1'b1;
      repeat (2) cyc();
      chk_all("idle after release", 0, 0, 0);

      // Pause 5 cycles mid-step delays the tick by 6 edges (12 instead of 6).
      drive(1, 0, 0, 1, 3, 1);
      cyc();
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) cyc();
      pause = 1'b1;
      cyc();
      chk("pause entry state", int'(state), 2);
      repeat (4) cyc();
      chk("paused count frozen", int'(count), 2);
      chk("paused state", int'(state), 2);
      pause = 1'b0;
      t = 8;
      got = 0;
      while (t < 40 && !got) begin
         cyc();
         t++;
         if (tick) got = 1;
      end
      chk("paused tick edge", got ? t : -1, 12);
      chk("paused tick count", int'(count), 0);

      // Restart from pause with load 7: prescaler restarts at 0.
      pause = 1'b1;
      cyc();
      chk("re-pause state", int'(state), 2);
      drive(1, 0, 1, 0, 7, 1);
      cyc();
      chk_all("start in pause", 7, 1, 0);
      drive(0, 0, 0, 0, 0, 0);
      cyc();
      chk("presc cleared hold", int'(count), 7);
      cyc();
      chk("presc cleared step", int'(count), 6);

      // Randomized run against the model, starting from idle.
      drive(0, 1, 0, 0, 0, 0);
      cyc();
      m_state = 0; m_count = 0; m_presc = 0; m_reload = 0; m_pdiv = 0; m_mode = 0;
      m_tick = 0;
      for (int i = 0; i < 3000; i++) begin
         bit s, p, ps, per;
         int ld, pd;
         s   = ($urandom_range(0, 24) == 0);
         p   = ($urandom_range(0, 79) == 0);
         ps  = ($urandom_range(0, 7) == 0) ? ~pause : pause;
         per = $urandom_range(0, 1);
         ld  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 6);
         pd  = $urandom_range(0, 3);
         drive(s, p, ps, per, ld, pd);
         model_edge(s, p, ps, per, ld, pd);
         cyc();
         if (count != WIDTH'(m_count) || state != 2'(m_state) || tick != m_tick[0] ||
             busy != (m_state == 1 || m_state == 2) || done != (m_state == 3)) begin
            chk_all($sformatf("rand%0d", i), m_count, m_state, m_tick);
         end else begin
            n_chk++;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
Programmable down-count timer controller. It sequences a WIDTH-bit counter register through start/pause/stop/reload, using a prescaler to divide clk into count steps. The block is the control layer above the plain counter/register primitives and generates the periodic or one-shot terminal-count events that other logic consumes. All outputs are registered.

Parameters:
WIDTH, 8, width of count, load value and reload register
PRE_WIDTH, 4, width of prescaler divide field; one step every (pre_div+1) clk cycles

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low; asserting (0) clears all state immediately
start  input  1  sampled per cycle; latch configuration and (re)start the timer
stop  input  1  sampled per cycle; abort and return to IDLE
pause  input  1  level; freezes the timer while high in RUN or PAUSE
periodic  input  1  mode latched at start: 1 auto-reload, 0 one-shot
load_val  input  WIDTH  initial and reload count, latched at start
pre_div  input  PRE_WIDTH  prescaler divide value, latched at start
count  output  WIDTH  current count value
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
busy  output  1  1 when state is RUN or PAUSE
done  output  1  1 when state is DONE
tick  output  1  single-cycle pulse on terminal count

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, prescaler=0, reload=0, latched pre_div=0, latched mode=0, tick=0, busy=0, done=0. While rst=0, all inputs are ignored. The first update after release occurs on the next clk edge.
- Command priority in every state: stop > start > pause.
- stop=1: next edge sets state=IDLE, count=0, prescaler=0, tick=0.
- start=1 (stop=0), from any state including RUN/PAUSE (restart):
  - Next edge sets count=load_val, reload=load_val, pre_div and periodic latched, prescaler=0, state=RUN, tick=0.
  - If load_val=0: state=DONE and tick=1 instead (one-shot), or state=RUN and tick=1 (periodic).
- Step event: state=RUN, pause=0, and prescaler==latched pre_div. On a step edge, prescaler clears to 0; otherwise in RUN with pause=0, prescaler increments.
- On a step with count>1: count decrements.
- On a step with count==1: count becomes 0 and tick=1 for exactly the next cycle. One-shot: state becomes DONE on the same edge. Periodic: stays RUN.
- On a step with count==0 (periodic only): count reloads to reload value. If reload=0: count stays 0 and tick=1 every step.
- Timing: start sampled at edge N with pre_div=P produces count 0 / tick at edge N+load_val*(P+1). Periodic tick period is (reload+1)*(P+1) cycles.
- Pause:
  - pause=1 in RUN: next edge enters PAUSE. count and prescaler hold; no step fires on that edge.
  - pause=0 in PAUSE: next edge returns to RUN, resuming with the preserved prescaler value.
  - pause has no effect in IDLE or DONE.
- DONE holds count=0 until start or stop. IDLE holds count=0 until start.
- tick is 0 in every cycle not listed above. Config inputs are ignored except at start.
- Counter and prescaler wrap is impossible by construction: the counter only decrements from ≥1, and the prescaler clears at pre_div.

Test Plan:
1. rst=0 mid-RUN with count=5 -> immediately count=0, state=0, tick=0, busy=0. After release with all inputs 0 -> stays IDLE.
2. One-shot, load_val=3, pre_div=0, start at edge N -> count 3,2,1,0 at N..N+3. tick=1 only in the cycle after N+3, state=DONE, done=1, count holds 0.
3. Periodic, load_val=2, pre_div=1 -> ticks exactly every 6 cycles, first at N+4. count sequence 2,2,1,1,0,0,2,2...
4. Periodic run, pause high for 5 cycles mid-step -> state=PAUSE; count and prescaler frozen. After release, next tick is delayed by exactly 5 (+1 entry) cycles vs unpaused.
5. start and stop high together in RUN -> IDLE, count=0. start alone during PAUSE with load_val=7 -> RUN, count=7, prescaler=0.
6. load_val=0: one-shot start -> DONE plus 1-cycle tick next edge. Periodic with pre_div=2 -> tick every 3 cycles, count stays 0.
